// File: rtl/wb_arb_pkg.sv
// Shared types and default parameters for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arbState_e;

    localparam int DEFAULT_TIMEOUT         = 255;
    localparam int DEFAULT_MAX_OUTSTANDING = 15;

endpackage

// File: rtl/wb_watchdog.sv
// Response watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th
// consecutive one; any clear restarts the count.
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic count_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // Expiry fires during the cycle that would make the count reach TIMEOUT.
    always_comb begin
        expire_o = count_i && !clear_i && (count_q == CW'(TIMEOUT - 1));
        count_d  = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with pipelined-request tracking and
// a no-ack watchdog that aborts a stuck bus owner.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT         = DEFAULT_TIMEOUT,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic [31:0] o_m0_data,
    output logic        o_m0_stall,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic [31:0] o_m1_data,
    output logic        o_m1_stall,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic [31:0] i_s_data,
    input  logic        i_s_stall,
    input  logic        i_s_ack
);

    arbState_e   state_q, state_d;
    logic        lastGrant_q, lastGrant_d;
    logic [3:0]  outstanding_q, outstanding_d;

    logic        mCyc, mStb, mWe;
    logic [31:0] mAddr, mData;
    logic        granted, full, grantStall, fwdAck, accept;
    logic        wdCount, wdClear, wdExpire;
    logic        ownStall, ownAck, ownErr;

    // lastGrant_q is updated on grant entry, so it also names the current owner.
    assign mCyc  = lastGrant_q ? i_m1_cyc  : i_m0_cyc;
    assign mStb  = lastGrant_q ? i_m1_stb  : i_m0_stb;
    assign mWe   = lastGrant_q ? i_m1_we   : i_m0_we;
    assign mAddr = lastGrant_q ? i_m1_addr : i_m0_addr;
    assign mData = lastGrant_q ? i_m1_data : i_m0_data;

    assign granted    = (state_q == GRANT0) || (state_q == GRANT1);
    assign full       = (outstanding_q == 4'(MAX_OUTSTANDING));
    assign grantStall = i_s_stall || full;
    assign fwdAck     = granted && i_s_ack && (outstanding_q != 4'd0) && !i_rst;

    assign wdCount = granted && (outstanding_q != 4'd0);
    assign wdClear = i_rst || !wdCount || i_s_ack;

    wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .count_i (wdCount),
        .clear_i (wdClear),
        .expire_o(wdExpire)
    );

    always_comb begin
        state_d       = state_q;
        lastGrant_d   = lastGrant_q;
        outstanding_d = outstanding_q;
        o_s_cyc       = 1'b0;
        o_s_stb       = 1'b0;
        o_s_we        = mWe;
        o_s_addr      = mAddr;
        o_s_data      = mData;
        o_m0_data     = i_s_data;
        o_m1_data     = i_s_data;
        o_m0_stall    = i_m0_cyc;
        o_m1_stall    = i_m1_cyc;
        o_m0_ack      = 1'b0;
        o_m1_ack      = 1'b0;
        o_m0_err      = 1'b0;
        o_m1_err      = 1'b0;
        ownStall      = 1'b1;
        ownAck        = 1'b0;
        ownErr        = 1'b0;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                outstanding_d = 4'd0;
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d     = lastGrant_q ? GRANT0 : GRANT1;
                    lastGrant_d = !lastGrant_q;
                end else if (i_m0_cyc) begin
                    state_d     = GRANT0;
                    lastGrant_d = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d     = GRANT1;
                    lastGrant_d = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                o_s_cyc  = mCyc;
                // Strobe is withheld when full so the slave never sees a request we stalled.
                o_s_stb  = mCyc && mStb && !full;
                ownStall = grantStall;
                ownAck   = fwdAck;
                ownErr   = wdExpire;
                accept   = o_s_stb && !grantStall;
                if (!mCyc) begin
                    state_d       = IDLE;
                    outstanding_d = 4'd0;
                end else if (wdExpire) begin
                    state_d       = ABORT;
                    outstanding_d = 4'd0;
                end else begin
                    outstanding_d = outstanding_q + {3'd0, accept} - {3'd0, fwdAck};
                end
            end
            ABORT: begin
                outstanding_d = 4'd0;
                if (!mCyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            if (lastGrant_q) begin
                o_m1_stall = ownStall;
                o_m1_ack   = ownAck;
                o_m1_err   = ownErr;
            end else begin
                o_m0_stall = ownStall;
                o_m0_ack   = ownAck;
                o_m0_err   = ownErr;
            end
        end

        if (i_rst) begin
            o_s_cyc  = 1'b0;
            o_s_stb  = 1'b0;
            o_m0_ack = 1'b0;
            o_m1_ack = 1'b0;
            o_m0_err = 1'b0;
            o_m1_err = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            lastGrant_q   <= 1'b1;
            outstanding_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            lastGrant_q   <= lastGrant_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: ack scoreboard on the default-parameter
// instance, plus a TIMEOUT=8 instance for the watchdog scenario.
module tb_wb_arbiter2;

    typedef struct packed {
        logic        master;
        logic [31:0] data;
    } sbEntry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
    logic [31:0] m0Addr, m0Data, m1Addr, m1Data;
    logic [31:0] sData;
    logic        sStall, sAck;

    logic [31:0] m0DataO, m1DataO, sAddr, sDataO;
    logic        m0Stall, m0Ack, m0Err, m1Stall, m1Ack, m1Err;
    logic        sCyc, sStb, sWe;

    logic [31:0] tM0DataO, tM1DataO, tSAddr, tSDataO;
    logic        tM0Stall, tM0Ack, tM0Err, tM1Stall, tM1Ack, tM1Err;
    logic        tSCyc, tSStb, tSWe;

    int       checks = 0;
    int       errors = 0;
    int       ackCount = 0;
    int       ackBase;
    sbEntry_t sbQ[$];

    wb_arbiter2 dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_cyc(m0Cyc), .i_m0_stb(m0Stb), .i_m0_we(m0We),
        .i_m0_addr(m0Addr), .i_m0_data(m0Data),
        .o_m0_data(m0DataO), .o_m0_stall(m0Stall), .o_m0_ack(m0Ack), .o_m0_err(m0Err),
        .i_m1_cyc(m1Cyc), .i_m1_stb(m1Stb), .i_m1_we(m1We),
        .i_m1_addr(m1Addr), .i_m1_data(m1Data),
        .o_m1_data(m1DataO), .o_m1_stall(m1Stall), .o_m1_ack(m1Ack), .o_m1_err(m1Err),
        .o_s_cyc(sCyc), .o_s_stb(sStb), .o_s_we(sWe), .o_s_addr(sAddr), .o_s_data(sDataO),
        .i_s_data(sData), .i_s_stall(sStall), .i_s_ack(sAck)
    );

    wb_arbiter2 #(.TIMEOUT(8)) dutT (
        .i_clk(clk), .i_rst(rst),
        .i_m0_cyc(m0Cyc), .i_m0_stb(m0Stb), .i_m0_we(m0We),
        .i_m0_addr(m0Addr), .i_m0_data(m0Data),
        .o_m0_data(tM0DataO), .o_m0_stall(tM0Stall), .o_m0_ack(tM0Ack), .o_m0_err(tM0Err),
        .i_m1_cyc(m1Cyc), .i_m1_stb(m1Stb), .i_m1_we(m1We),
        .i_m1_addr(m1Addr), .i_m1_data(m1Data),
        .o_m1_data(tM1DataO), .o_m1_stall(tM1Stall), .o_m1_ack(tM1Ack), .o_m1_err(tM1Err),
        .o_s_cyc(tSCyc), .o_s_stb(tSStb), .o_s_we(tSWe), .o_s_addr(tSAddr), .o_s_data(tSDataO),
        .i_s_data(sData), .i_s_stall(sStall), .i_s_ack(sAck)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit m, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] addr, input logic [31:0] data);
        if (m) begin
            m1Cyc = cyc; m1Stb = stb; m1We = we; m1Addr = addr; m1Data = data;
        end else begin
            m0Cyc = cyc; m0Stb = stb; m0We = we; m0Addr = addr; m0Data = data;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleEdge();
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        sData = 32'h0; sStall = 1'b0; sAck = 1'b0;
        nextCycle();
        nextCycle();
        sampleEdge();
        checkOutput("rst_s_cyc_stb", {30'd0, sCyc, sStb}, 32'h0);
        checkOutput("rst_ack_err", {28'd0, m0Ack, m1Ack, m0Err, m1Err}, 32'h0);
        nextCycle();
        rst = 1'b0;
    endtask

    // Every forwarded ack must match the oldest expectation in order.
    always @(negedge clk) begin : scoreboard
        sbEntry_t e;
        if (m0Ack || m1Ack) begin
            ackCount++;
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_ack", {30'd0, m1Ack, m0Ack}, 32'h0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_ack_master", {30'd0, m1Ack, m0Ack}, e.master ? 32'd2 : 32'd1);
                checkOutput("sb_ack_data", e.master ? m1DataO : m0DataO, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        sData = 32'h0; sStall = 1'b0; sAck = 1'b0;

        // Single master write to a slave that acks one cycle after accepting.
        resetDut();
        applyStimulus(0, 1, 1, 1, 32'h1000_0000, 32'h41);
        sampleEdge();
        checkOutput("w_c0_s_cyc", sCyc, 0);
        checkOutput("w_c0_m0_stall", m0Stall, 1);
        nextCycle();
        sampleEdge();
        checkOutput("w_c1_s_cyc", sCyc, 1);
        checkOutput("w_c1_s_stb", sStb, 1);
        checkOutput("w_c1_s_data", sDataO, 32'h41);
        checkOutput("w_c1_s_addr", sAddr, 32'h1000_0000);
        checkOutput("w_c1_s_we", sWe, 1);
        checkOutput("w_c1_m0_stall", m0Stall, 0);
        nextCycle();
        applyStimulus(0, 1, 0, 1, 32'h1000_0000, 32'h41);
        applyStimulus(1, 1, 0, 0, 32'h2000_0000, 0);
        sampleEdge();
        checkOutput("w_c2_m0_ack", m0Ack, 0);
        checkOutput("w_c2_m1_stall", m1Stall, 1);
        checkOutput("w_c2_s_stb", sStb, 0);
        nextCycle();
        sAck = 1'b1; sData = 32'h0000_00A5;
        sbQ.push_back('{master: 1'b0, data: 32'h0000_00A5});
        sampleEdge();
        checkOutput("w_c3_m0_ack", m0Ack, 1);
        checkOutput("w_c3_m1_ack", m1Ack, 0);
        checkOutput("w_c3_m1_data", m1DataO, 32'h0000_00A5);
        nextCycle();
        sAck = 1'b0;

        // Simultaneous requests, handover through IDLE, then a stalled read by m1.
        resetDut();
        applyStimulus(0, 1, 0, 0, 32'h3000_0000, 0);
        applyStimulus(1, 1, 0, 0, 32'h2000_0000, 0);
        sampleEdge();
        checkOutput("rr_c0_stalls", {30'd0, m1Stall, m0Stall}, 32'h3);
        checkOutput("rr_c0_s_cyc", sCyc, 0);
        nextCycle();
        sampleEdge();
        checkOutput("rr_c1_s_cyc", sCyc, 1);
        checkOutput("rr_c1_s_addr", sAddr, 32'h3000_0000);
        checkOutput("rr_c1_stalls", {30'd0, m1Stall, m0Stall}, 32'h2);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleEdge();
        checkOutput("rr_c2_s_cyc", sCyc, 0);
        nextCycle();
        sampleEdge();
        checkOutput("rr_c3_idle_s_cyc", sCyc, 0);
        checkOutput("rr_c3_m1_stall", m1Stall, 1);
        nextCycle();
        applyStimulus(1, 1, 1, 0, 32'h2000_0010, 0);
        sStall = 1'b1;
        ackBase = ackCount;
        sampleEdge();
        checkOutput("rr_c4_s_cyc", sCyc, 1);
        checkOutput("rr_c4_s_addr", sAddr, 32'h2000_0010);
        checkOutput("st_c4_m1_stall", m1Stall, 1);
        for (int i = 5; i <= 8; i++) begin
            nextCycle();
            sampleEdge();
            checkOutput($sformatf("st_c%0d_m1_stall", i), m1Stall, 1);
        end
        nextCycle();
        sStall = 1'b0;
        sampleEdge();
        checkOutput("st_c9_m1_stall", m1Stall, 0);
        checkOutput("st_c9_s_stb", sStb, 1);
        nextCycle();
        applyStimulus(1, 1, 0, 0, 32'h2000_0010, 0);
        sampleEdge();
        checkOutput("st_c10_m1_ack", m1Ack, 0);
        nextCycle();
        sAck = 1'b1; sData = 32'hDEAD_BEEF;
        sbQ.push_back('{master: 1'b1, data: 32'hDEAD_BEEF});
        sampleEdge();
        checkOutput("st_c11_m1_ack", m1Ack, 1);
        nextCycle();
        sData = 32'h1234_5678;
        sampleEdge();
        checkOutput("st_c12_stray_ack", m1Ack, 0);
        nextCycle();
        sAck = 1'b0;
        sampleEdge();
        checkOutput("st_ack_count", ackCount - ackBase, 1);

        // Slave never acks: TIMEOUT=8 instance must error and abort.
        resetDut();
        applyStimulus(0, 1, 1, 0, 32'h4000_0000, 0);
        sampleEdge();
        nextCycle();
        sampleEdge();
        checkOutput("to_c1_s_cyc", tSCyc, 1);
        checkOutput("to_c1_m0_stall", tM0Stall, 0);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 32'h4000_0000, 0);
        sampleEdge();
        checkOutput("to_c2_m0_err", tM0Err, 0);
        for (int i = 3; i <= 8; i++) begin
            nextCycle();
            sampleEdge();
            checkOutput($sformatf("to_c%0d_m0_err", i), tM0Err, 0);
        end
        nextCycle();
        sampleEdge();
        checkOutput("to_c9_m0_err", tM0Err, 1);
        checkOutput("to_c9_default_no_err", m0Err, 0);
        nextCycle();
        sampleEdge();
        checkOutput("to_c10_m0_err", tM0Err, 0);
        checkOutput("to_c10_s_cyc", tSCyc, 0);
        checkOutput("to_c10_m0_stall", tM0Stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Pipelined strobes with acks withheld: 15 accepted, the 16th waits for an ack.
        resetDut();
        applyStimulus(0, 1, 1, 1, 32'h5000_0000, 32'h77);
        sampleEdge();
        for (int i = 1; i <= 15; i++) begin
            nextCycle();
            sampleEdge();
            checkOutput($sformatf("pl_c%0d_m0_stall", i), m0Stall, 0);
        end
        nextCycle();
        sampleEdge();
        checkOutput("pl_c16_m0_stall", m0Stall, 1);
        checkOutput("pl_c16_s_stb", sStb, 0);
        nextCycle();
        sampleEdge();
        checkOutput("pl_c17_m0_stall", m0Stall, 1);
        nextCycle();
        sAck = 1'b1; sData = 32'h0000_0100;
        sbQ.push_back('{master: 1'b0, data: 32'h0000_0100});
        sampleEdge();
        checkOutput("pl_c18_m0_ack", m0Ack, 1);
        checkOutput("pl_c18_m0_stall", m0Stall, 1);
        nextCycle();
        sAck = 1'b0;
        sampleEdge();
        checkOutput("pl_c19_m0_stall", m0Stall, 0);
        checkOutput("pl_c19_s_stb", sStb, 1);
        nextCycle();
        applyStimulus(0, 1, 0, 1, 32'h5000_0000, 32'h77);
        sampleEdge();
        checkOutput("pl_c20_full_stall", m0Stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleEdge();
        checkOutput("pl_c21_release_s_cyc", sCyc, 0);
        nextCycle();
        sAck = 1'b1;
        sampleEdge();
        checkOutput("pl_c22_late_ack", m0Ack, 0);
        nextCycle();
        sAck = 1'b0;

        // Reset in the middle of an m1 burst with three requests outstanding.
        resetDut();
        applyStimulus(1, 1, 1, 0, 32'h6000_0000, 0);
        sampleEdge();
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            sampleEdge();
            checkOutput($sformatf("mr_c%0d_m1_stall", i), m1Stall, 0);
        end
        nextCycle();
        applyStimulus(1, 1, 0, 0, 32'h6000_0000, 0);
        rst = 1'b1; sAck = 1'b1; sData = 32'hBAD0_0001;
        sampleEdge();
        checkOutput("mr_c4_s_cyc", sCyc, 0);
        checkOutput("mr_c4_m1_ack", m1Ack, 0);
        nextCycle();
        rst = 1'b0;
        sampleEdge();
        checkOutput("mr_c5_s_cyc", sCyc, 0);
        checkOutput("mr_c5_m1_ack", m1Ack, 0);
        checkOutput("mr_c5_m1_stall", m1Stall, 1);
        nextCycle();
        sampleEdge();
        checkOutput("mr_c6_s_cyc", sCyc, 1);
        checkOutput("mr_c6_m1_ack", m1Ack, 0);
        nextCycle();
        sAck = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        sampleEdge();

        checkOutput("sb_drained", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
